// File: rtl/sprite_motion_ctrl.sv
// Sprite mover: steps qx/qy once per frame tick; IDLE/RUN/HOLD with optional dwell after row wrap.
// All outputs registered, one cycle after the qualifying tick; no backpressure, inputs sampled every cycle.
module sprite_motion_ctrl #(
   parameter int CORDW      = 10,
   parameter int H_RES_FULL = 800,
   parameter int V_RES_FULL = 525,
   parameter int V_RES      = 480,
   parameter int Q_SIZE     = 32
) (
   input  logic             clk_pix,
   input  logic             rst,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic             run,
   input  logic             step,
   input  logic [3:0]       speed,
   input  logic [7:0]       hold_frames,
   output logic [CORDW-1:0] qx,
   output logic [CORDW-1:0] qy,
   output logic             busy,
   output logic             row_done,
   output logic [15:0]      frame_cnt
);

   localparam logic [CORDW-1:0] X_WRAP = CORDW'(H_RES_FULL - Q_SIZE);
   localparam logic [CORDW-1:0] Y_WRAP = CORDW'(V_RES_FULL - Q_SIZE);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state_q;
   logic [CORDW-1:0] qx_q, qy_q;
   logic [CORDW-1:0] qx_d, qy_d;
   logic             busy_q, row_done_q, step_pend_q;
   logic [15:0]      frame_cnt_q;
   logic [7:0]       hold_cnt_q;
   logic             tick, wrap, move_ok;

   assign tick    = (sy == CORDW'(V_RES)) && (sx == '0);
   // speed 0 must neither move nor wrap, so it disqualifies the whole move
   assign move_ok = (speed != 4'd0);
   assign wrap    = (qx_q >= X_WRAP);

   always_comb begin
      qx_d = qx_q + CORDW'(speed);
      qy_d = qy_q;
      if (wrap) begin
         qx_d = '0;
         qy_d = (qy_q >= Y_WRAP) ? '0 : qy_q + CORDW'(Q_SIZE);
      end
   end

   always_ff @(posedge clk_pix or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         qx_q        <= '0;
         qy_q        <= '0;
         busy_q      <= 1'b0;
         row_done_q  <= 1'b0;
         step_pend_q <= 1'b0;
         frame_cnt_q <= '0;
         hold_cnt_q  <= '0;
      end else begin
         row_done_q <= 1'b0;
         if (tick) frame_cnt_q <= frame_cnt_q + 16'd1;

         case (state_q)
            IDLE: begin
               if (run) begin
                  state_q     <= RUN;
                  busy_q      <= 1'b1;
                  step_pend_q <= 1'b0;
               end else if (tick && step_pend_q) begin
                  step_pend_q <= 1'b0;
                  if (move_ok) begin
                     qx_q       <= qx_d;
                     qy_q       <= qy_d;
                     row_done_q <= wrap;
                  end
               end else if (step) begin
                  step_pend_q <= 1'b1;
               end
            end

            RUN: begin
               if (!run) begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  step_pend_q <= 1'b0;
               end else if (tick && move_ok) begin
                  qx_q       <= qx_d;
                  qy_q       <= qy_d;
                  row_done_q <= wrap;
                  if (wrap && hold_frames != 8'd0) begin
                     state_q    <= HOLD;
                     hold_cnt_q <= hold_frames;
                  end
               end
            end

            HOLD: begin
               if (!run) begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  hold_cnt_q  <= '0;
                  step_pend_q <= 1'b0;
               end else if (tick) begin
                  // last dwell tick only re-arms RUN; motion resumes on the next tick
                  if (hold_cnt_q <= 8'd1) begin
                     state_q    <= RUN;
                     hold_cnt_q <= '0;
                  end else begin
                     hold_cnt_q <= hold_cnt_q - 8'd1;
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign qx        = qx_q;
   assign qy        = qy_q;
   assign busy      = busy_q;
   assign row_done  = row_done_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl; expectations queued by stimulus, compared by a negedge monitor.
module tb_sprite_motion_ctrl;

   localparam int V_RES = 480;

   logic       clk_pix = 1'b0;
   logic       rst, run, step;
   logic [9:0] sx, sy;
   logic [3:0] speed;
   logic [7:0] hold_frames;
   logic [9:0] qx, qy;
   logic       busy, row_done;
   logic [15:0] frame_cnt;

   sprite_motion_ctrl dut (
      .clk_pix    (clk_pix),
      .rst        (rst),
      .sx         (sx),
      .sy         (sy),
      .run        (run),
      .step       (step),
      .speed      (speed),
      .hold_frames(hold_frames),
      .qx         (qx),
      .qy         (qy),
      .busy       (busy),
      .row_done   (row_done),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk_pix = ~clk_pix;

   typedef struct {
      int          cyc;
      string       name;
      logic [9:0]  qx;
      logic [9:0]  qy;
      logic        rd;
      logic        busy;
      logic [15:0] fc;
   } exp_t;

   exp_t  sb[$];
   exp_t  mon_e;
   int    cyc = 0;
   int    n_chk = 0;
   int    n_pass = 0;
   logic [15:0] fc;

   always @(posedge clk_pix) cyc <= cyc + 1;

   // Monitor: every negedge, retire the expectations due this cycle
   always @(negedge clk_pix) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         n_chk++;
         if ({qx, qy, row_done, busy, frame_cnt} ===
             {mon_e.qx, mon_e.qy, mon_e.rd, mon_e.busy, mon_e.fc}) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got qx=%0d qy=%0d rd=%0b busy=%0b fc=%0d, want qx=%0d qy=%0d rd=%0b busy=%0b fc=%0d",
                     mon_e.name, qx, qy, row_done, busy, frame_cnt,
                     mon_e.qx, mon_e.qy, mon_e.rd, mon_e.busy, mon_e.fc);
         end
      end
   end

   task automatic step_clk();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic push(input int c, input string nm, input logic [9:0] eqx, input logic [9:0] eqy,
                       input logic erd, input logic ebusy);
      exp_t e;
      e.cyc = c; e.name = nm; e.qx = eqx; e.qy = eqy; e.rd = erd; e.busy = ebusy; e.fc = fc;
      sb.push_back(e);
   endtask

   task automatic expect_now(input string nm, input logic [9:0] eqx, input logic [9:0] eqy,
                             input logic ebusy);
      push(cyc, nm, eqx, eqy, 1'b0, ebusy);
   endtask

   task automatic tick_drive();
      sy = 10'(V_RES);
      sx = 10'd0;
      step_clk();
      sx = 10'd1;
      sy = 10'd0;
      fc = fc + 16'd1;
   endtask

   task automatic tick_only();
      tick_drive();
      step_clk();
   endtask

   // Checks the cycle after the tick and the one after that (row_done must have dropped)
   task automatic tick_chk(input string nm, input logic [9:0] eqx, input logic [9:0] eqy,
                           input logic erd, input logic ebusy);
      tick_drive();
      push(cyc, nm, eqx, eqy, erd, ebusy);
      push(cyc + 1, {nm, "_nxt"}, eqx, eqy, 1'b0, ebusy);
      step_clk();
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; step = 1'b0; speed = 4'd0; hold_frames = 8'd0;
      sx = 10'd1; sy = 10'd0; fc = 16'd0;
      step_clk();
      step_clk();
      expect_now("reset", 10'd0, 10'd0, 1'b0);
      step_clk();
      rst = 1'b0;
      step_clk();

      // continuous run, speed 4
      speed = 4'd4; run = 1'b1;
      step_clk();
      expect_now("run_busy", 10'd0, 10'd0, 1'b1);
      tick_chk("run_f1", 10'd4, 10'd0, 1'b0, 1'b1);
      tick_chk("run_f2", 10'd8, 10'd0, 1'b0, 1'b1);
      tick_chk("run_f3", 10'd12, 10'd0, 1'b0, 1'b1);

      // advance to qx=764 then across the row wrap threshold of 768
      for (int i = 0; i < 188; i++) tick_only();
      tick_chk("x768", 10'd768, 10'd0, 1'b0, 1'b1);
      tick_chk("row_wrap", 10'd0, 10'd32, 1'b1, 1'b1);
      tick_chk("after_wrap", 10'd4, 10'd32, 1'b0, 1'b1);

      // zero speed: no motion, frame count still advances
      speed = 4'd0;
      tick_chk("spd0_a", 10'd4, 10'd32, 1'b0, 1'b1);
      tick_chk("spd0_b", 10'd4, 10'd32, 1'b0, 1'b1);

      // dwell of 2 frames after a wrap
      speed = 4'd15; hold_frames = 8'd2;
      for (int i = 0; i < 50; i++) tick_only();
      tick_chk("x769", 10'd769, 10'd32, 1'b0, 1'b1);
      tick_chk("hold_wrap", 10'd0, 10'd64, 1'b1, 1'b1);
      tick_chk("hold_t1", 10'd0, 10'd64, 1'b0, 1'b1);
      tick_chk("hold_t2", 10'd0, 10'd64, 1'b0, 1'b1);
      tick_chk("hold_resume", 10'd15, 10'd64, 1'b0, 1'b1);

      // walk rows down to qy=512 and wrap the frame back to qy=0
      hold_frames = 8'd0;
      for (int i = 0; i < 51; i++) tick_only();
      tick_chk("wrap_y96", 10'd0, 10'd96, 1'b1, 1'b1);
      for (int r = 0; r < 13; r++)
         for (int i = 0; i < 53; i++) tick_only();
      for (int i = 0; i < 51; i++) tick_only();
      tick_chk("x780_y512", 10'd780, 10'd512, 1'b0, 1'b1);
      tick_chk("wrap_y0", 10'd0, 10'd0, 1'b1, 1'b1);

      // stop with a tick in the same cycle: no move
      tick_chk("pre_stop", 10'd15, 10'd0, 1'b0, 1'b1);
      run = 1'b0;
      tick_chk("stop_tick", 10'd15, 10'd0, 1'b0, 1'b0);

      // single step; second pulse while pending must not queue another move
      step = 1'b1; step_clk(); step = 1'b0; step_clk();
      step = 1'b1; step_clk(); step = 1'b0; step_clk();
      expect_now("step_wait", 10'd15, 10'd0, 1'b0);
      tick_chk("step_move", 10'd30, 10'd0, 1'b0, 1'b0);
      tick_chk("step_once", 10'd30, 10'd0, 1'b0, 1'b0);

      // reset in the middle of a 5-frame dwell
      hold_frames = 8'd5; run = 1'b1;
      step_clk();
      for (int i = 0; i < 49; i++) tick_only();
      tick_chk("h5_x780", 10'd780, 10'd0, 1'b0, 1'b1);
      tick_chk("h5_wrap", 10'd0, 10'd32, 1'b1, 1'b1);
      tick_chk("h5_hold", 10'd0, 10'd32, 1'b0, 1'b1);
      step_clk();
      rst = 1'b1; fc = 16'd0;
      expect_now("rst_async", 10'd0, 10'd0, 1'b0);
      step_clk();
      rst = 1'b0;
      expect_now("rel_idle", 10'd0, 10'd0, 1'b0);
      step_clk();
      expect_now("rel_run", 10'd0, 10'd0, 1'b1);
      tick_chk("rel_move", 10'd15, 10'd0, 1'b0, 1'b1);

      for (int i = 0; i < 20 && sb.size() > 0; i++) step_clk();
      if (sb.size() > 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
